// File: rtl/ibex_pkg_pext.sv
// Shared types and constants for the P-extension execute-stage control slice.
package ibex_pkg_pext;

  // Width of each intermediate-value register exchanged with the ALU.
  localparam int unsigned IMD_W = 34;

  // Execute-stage sequencer states.
  typedef enum logic [1:0] {
    EX_IDLE  = 2'd0,
    EX_MULTI = 2'd1,
    EX_HOLD  = 2'd2
  } ex_ctrl_state_e;

endpackage

// File: rtl/ibex_pext_imd_regs.sv
// Two intermediate-value registers for multicycle ALU operations.
// Each register has its own write enable; a flush blocks all writes.
module ibex_pext_imd_regs
  import ibex_pkg_pext::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [1:0]            we,
  input  logic [1:0][IMD_W-1:0] wdata,
  output logic [1:0][IMD_W-1:0] rdata
);

  logic [1:0][IMD_W-1:0] regs;

  // Per-register update; a flush keeps the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (we[r] && !flush) begin
          regs[r] <= wdata[r];
        end
      end
    end
  end

  assign rdata = regs;

endmodule

// File: rtl/ibex_pext_ex_ctrl.sv
// Execute-stage sequencer for ibex_alu_pext: request handshake with ID,
// multicycle enables, imd_val storage, result buffering under writeback
// backpressure, and the sticky vxsat bit.
// Optional MULTI-state watchdog: define IBEX_PEXT_WATCHDOG_EN.
module ibex_pext_ex_ctrl
  import ibex_pkg_pext::*;
#(
  parameter int unsigned MaxMultiCycles = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic                  req_multi_i,
  input  logic                  req_mult_i,
  output logic                  req_ready_o,
  input  logic                  flush_i,
  output logic                  alu_mult_en_o,
  output logic                  alu_div_en_o,
  output logic                  alu_multdiv_ready_id_o,
  input  logic [1:0][IMD_W-1:0] alu_imd_val_d_i,
  input  logic [1:0]            alu_imd_val_we_i,
  output logic [1:0][IMD_W-1:0] alu_imd_val_q_o,
  input  logic [31:0]           alu_result_i,
  input  logic                  alu_valid_i,
  input  logic                  alu_set_ov_i,
  output logic                  ex_valid_o,
  output logic [31:0]           ex_result_o,
  input  logic                  wb_ready_i,
  input  logic                  csr_vxsat_we_i,
  input  logic                  csr_vxsat_wdata_i,
  output logic                  vxsat_o,
  output logic                  watchdog_err_o
);

  localparam int unsigned CntW = $clog2(MaxMultiCycles + 1);

  ex_ctrl_state_e state_q, state_d;
  logic [31:0]    result_q, result_d;
  logic           ov_q, ov_d;
  logic           hold_multi_q, hold_multi_d;
  logic           mult_q, mult_d;
  logic           vxsat_q, vxsat_d;
  logic           timeout;
  logic           retire_ov;
  logic [1:0]     imd_we;

`ifdef IBEX_PEXT_WATCHDOG_EN
  logic [CntW-1:0] cnt_q, cnt_d;

  // Cycle counter: held at zero outside MULTI, saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != EX_MULTI) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(MaxMultiCycles)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (state_q == EX_MULTI) && (cnt_q == CntW'(MaxMultiCycles)) &&
                   !alu_valid_i && !flush_i;
`else
  logic unused_cfg;
  assign unused_cfg = |CntW'(MaxMultiCycles);
  assign timeout    = 1'b0;
`endif

  assign watchdog_err_o = timeout;

  // Next-state and handshake decode; flush overrides everything.
  always_comb begin
    state_d                = state_q;
    result_d               = result_q;
    ov_d                   = ov_q;
    hold_multi_d           = hold_multi_q;
    mult_d                 = mult_q;
    ex_valid_o             = 1'b0;
    ex_result_o            = '0;
    req_ready_o            = 1'b0;
    alu_mult_en_o          = 1'b0;
    alu_div_en_o           = 1'b0;
    alu_multdiv_ready_id_o = 1'b0;
    imd_we                 = '0;
    retire_ov              = 1'b0;

    if (flush_i) begin
      state_d = EX_IDLE;
    end else begin
      unique case (state_q)
        EX_IDLE: begin
          if (req_valid_i) begin
            if (!req_multi_i) begin
              ex_valid_o  = 1'b1;
              ex_result_o = alu_result_i;
              if (wb_ready_i) begin
                req_ready_o = 1'b1;
                retire_ov   = alu_set_ov_i;
              end else begin
                result_d     = alu_result_i;
                ov_d         = alu_set_ov_i;
                hold_multi_d = 1'b0;
                state_d      = EX_HOLD;
              end
            end else begin
              alu_mult_en_o = req_mult_i;
              alu_div_en_o  = !req_mult_i;
              mult_d        = req_mult_i;
              state_d       = EX_MULTI;
            end
          end
        end

        EX_MULTI: begin
          alu_mult_en_o = mult_q;
          alu_div_en_o  = !mult_q;
          imd_we        = alu_imd_val_we_i;
          if (alu_valid_i || timeout) begin
            ex_valid_o  = 1'b1;
            ex_result_o = timeout ? 32'h0 : alu_result_i;
            if (wb_ready_i) begin
              req_ready_o            = 1'b1;
              alu_multdiv_ready_id_o = 1'b1;
              retire_ov              = timeout ? 1'b0 : alu_set_ov_i;
              state_d                = EX_IDLE;
            end else begin
              result_d     = timeout ? 32'h0 : alu_result_i;
              ov_d         = timeout ? 1'b0 : alu_set_ov_i;
              hold_multi_d = 1'b1;
              state_d      = EX_HOLD;
            end
          end
        end

        EX_HOLD: begin
          ex_valid_o  = 1'b1;
          ex_result_o = result_q;
          if (wb_ready_i) begin
            req_ready_o            = 1'b1;
            alu_multdiv_ready_id_o = hold_multi_q;
            retire_ov              = ov_q;
            state_d                = EX_IDLE;
          end
        end

        default: begin
          state_d = EX_IDLE;
        end
      endcase
    end
  end

  // A CSR write replaces vxsat, but a saturating retire in the same cycle still sets it.
  always_comb begin
    vxsat_d = (csr_vxsat_we_i ? csr_vxsat_wdata_i : vxsat_q) | retire_ov;
  end

  // State, buffered result and vxsat registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= EX_IDLE;
      result_q     <= '0;
      ov_q         <= 1'b0;
      hold_multi_q <= 1'b0;
      mult_q       <= 1'b0;
      vxsat_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      ov_q         <= ov_d;
      hold_multi_q <= hold_multi_d;
      mult_q       <= mult_d;
      vxsat_q      <= vxsat_d;
    end
  end

  assign vxsat_o = vxsat_q;

  ibex_pext_imd_regs u_imd_regs (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (flush_i),
    .we    (imd_we),
    .wdata (alu_imd_val_d_i),
    .rdata (alu_imd_val_q_o)
  );

endmodule

// File: tb/tb_ibex_pext_ex_ctrl.sv
// Directed bench for ibex_pext_ex_ctrl with a result scoreboard.
// Expected writeback results are queued as stimulus is issued; a monitor
// pops and compares each time a result is accepted by writeback.
module tb_ibex_pext_ex_ctrl;
  import ibex_pkg_pext::*;

`ifdef IBEX_PEXT_WATCHDOG_EN
  localparam int unsigned TbMax = 4;
`else
  localparam int unsigned TbMax = 40;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  req_valid_i;
  logic                  req_multi_i;
  logic                  req_mult_i;
  logic                  req_ready_o;
  logic                  flush_i;
  logic                  alu_mult_en_o;
  logic                  alu_div_en_o;
  logic                  alu_multdiv_ready_id_o;
  logic [1:0][IMD_W-1:0] alu_imd_val_d_i;
  logic [1:0]            alu_imd_val_we_i;
  logic [1:0][IMD_W-1:0] alu_imd_val_q_o;
  logic [31:0]           alu_result_i;
  logic                  alu_valid_i;
  logic                  alu_set_ov_i;
  logic                  ex_valid_o;
  logic [31:0]           ex_result_o;
  logic                  wb_ready_i;
  logic                  csr_vxsat_we_i;
  logic                  csr_vxsat_wdata_i;
  logic                  vxsat_o;
  logic                  watchdog_err_o;

  int          checks = 0;
  int          passes = 0;
  int          sb_checks = 0;
  int          sb_passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;
  int          en_cnt;
  int          rdy_cnt;
  logic        wd_seen;
  logic        ev_seen;

  always #5 clk_i = ~clk_i;

  ibex_pext_ex_ctrl #(
    .MaxMultiCycles(TbMax)
  ) dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .req_valid_i            (req_valid_i),
    .req_multi_i            (req_multi_i),
    .req_mult_i             (req_mult_i),
    .req_ready_o            (req_ready_o),
    .flush_i                (flush_i),
    .alu_mult_en_o          (alu_mult_en_o),
    .alu_div_en_o           (alu_div_en_o),
    .alu_multdiv_ready_id_o (alu_multdiv_ready_id_o),
    .alu_imd_val_d_i        (alu_imd_val_d_i),
    .alu_imd_val_we_i       (alu_imd_val_we_i),
    .alu_imd_val_q_o        (alu_imd_val_q_o),
    .alu_result_i           (alu_result_i),
    .alu_valid_i            (alu_valid_i),
    .alu_set_ov_i           (alu_set_ov_i),
    .ex_valid_o             (ex_valid_o),
    .ex_result_o            (ex_result_o),
    .wb_ready_i             (wb_ready_i),
    .csr_vxsat_we_i         (csr_vxsat_we_i),
    .csr_vxsat_wdata_i      (csr_vxsat_wdata_i),
    .vxsat_o                (vxsat_o),
    .watchdog_err_o         (watchdog_err_o)
  );

  // Scoreboard monitor: every accepted writeback result must match the queue head.
  always @(negedge clk_i) begin
    if (rst_ni && ex_valid_o && wb_ready_i) begin
      sb_checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL sb_unexpected: got result %08h, expected no result", ex_result_o);
      end else begin
        sb_exp = exp_q.pop_front();
        if (ex_result_o === sb_exp) begin
          sb_passes++;
        end else begin
          $display("[TB] FAIL sb_result: got %08h, expected %08h", ex_result_o, sb_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic valid, input logic multi, input logic mult,
                               input logic [31:0] result, input logic avalid,
                               input logic ov, input logic wb);
    req_valid_i  = valid;
    req_multi_i  = multi;
    req_mult_i   = mult;
    alu_result_i = result;
    alu_valid_i  = avalid;
    alu_set_ov_i = ov;
    wb_ready_i   = wb;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0);
    flush_i           = 1'b0;
    alu_imd_val_d_i   = '0;
    alu_imd_val_we_i  = '0;
    csr_vxsat_we_i    = 1'b0;
    csr_vxsat_wdata_i = 1'b0;

    // Reset values
    repeat (2) @(posedge clk_i);
    sample();
    checkOutput("rst_ex_valid", ex_valid_o, 0);
    checkOutput("rst_req_ready", req_ready_o, 0);
    checkOutput("rst_vxsat", vxsat_o, 0);
    checkOutput("rst_imd0", alu_imd_val_q_o[0], 0);
    checkOutput("rst_imd1", alu_imd_val_q_o[1], 0);
    checkOutput("rst_mult_en", alu_mult_en_o, 0);
    checkOutput("rst_ex_result", ex_result_o, 0);
    checkOutput("rst_watchdog", watchdog_err_o, 0);
    step();
    rst_ni = 1'b1;

    // Single-cycle op retires immediately
    step();
    applyStimulus(1, 0, 0, 32'h12345678, 0, 0, 1);
    exp_q.push_back(32'h12345678);
    sample();
    checkOutput("single_req_ready", req_ready_o, 1);
    checkOutput("single_multdiv_rdy", alu_multdiv_ready_id_o, 0);
    step();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    sample();
    checkOutput("single_idle_after", ex_valid_o, 0);

    // Backpressure: three stalled cycles, result held while ALU output changes
    step();
    applyStimulus(1, 0, 0, 32'h12345678, 0, 0, 0);
    sample();
    checkOutput("bp_ex_valid", ex_valid_o, 1);
    checkOutput("bp_ready_low0", req_ready_o, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      applyStimulus(1, 0, 0, 32'h0, 0, 0, 0);
      sample();
      checkOutput("bp_held_result", ex_result_o, 32'h12345678);
      checkOutput("bp_ready_low", req_ready_o, 0);
    end
    step();
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 1);
    exp_q.push_back(32'h12345678);
    sample();
    checkOutput("bp_ready_cycle4", req_ready_o, 1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);

    // Multicycle multiply with one imd write
    en_cnt  = 0;
    rdy_cnt = 0;
    step();
    applyStimulus(1, 1, 1, 32'h0, 0, 0, 1);
    sample();
    checkOutput("mul_en_first", alu_mult_en_o, 1);
    checkOutput("mul_div_en", alu_div_en_o, 0);
    en_cnt += int'(alu_mult_en_o);
    rdy_cnt += int'(alu_multdiv_ready_id_o);
    step();
    alu_imd_val_we_i   = 2'b01;
    alu_imd_val_d_i[0] = 34'h1_0000_0001;
    alu_imd_val_d_i[1] = 34'h2_AAAA_5555;
    sample();
    checkOutput("mul_no_ex_valid", ex_valid_o, 0);
    en_cnt += int'(alu_mult_en_o);
    rdy_cnt += int'(alu_multdiv_ready_id_o);
    step();
    alu_imd_val_we_i = 2'b00;
    alu_imd_val_d_i  = '0;
    sample();
    checkOutput("mul_imd0", alu_imd_val_q_o[0], 34'h1_0000_0001);
    checkOutput("mul_imd1", alu_imd_val_q_o[1], 0);
    en_cnt += int'(alu_mult_en_o);
    rdy_cnt += int'(alu_multdiv_ready_id_o);
    step();
    applyStimulus(1, 1, 1, 32'hCAFEF00D, 1, 0, 1);
    exp_q.push_back(32'hCAFEF00D);
    sample();
    checkOutput("mul_req_ready", req_ready_o, 1);
    checkOutput("mul_multdiv_rdy", alu_multdiv_ready_id_o, 1);
    en_cnt += int'(alu_mult_en_o);
    rdy_cnt += int'(alu_multdiv_ready_id_o);
    step();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    sample();
    checkOutput("mul_en_dropped", alu_mult_en_o, 0);
    en_cnt += int'(alu_mult_en_o);
    rdy_cnt += int'(alu_multdiv_ready_id_o);
    checkOutput("mul_en_cycles", en_cnt, 4);
    checkOutput("mul_rdy_pulses", rdy_cnt, 1);

    // Overflow and vxsat CSR interaction
    step();
    applyStimulus(1, 0, 0, 32'h7FFFFFFF, 0, 1, 1);
    exp_q.push_back(32'h7FFFFFFF);
    sample();
    step();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    csr_vxsat_we_i    = 1'b1;
    csr_vxsat_wdata_i = 1'b0;
    sample();
    checkOutput("ov_vxsat_set", vxsat_o, 1);
    step();
    applyStimulus(1, 0, 0, 32'h80000000, 0, 1, 1);
    exp_q.push_back(32'h80000000);
    sample();
    checkOutput("ov_csr_clear", vxsat_o, 0);
    step();
    csr_vxsat_we_i = 1'b0;
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    sample();
    checkOutput("ov_set_beats_csr", vxsat_o, 1);
    step();
    csr_vxsat_we_i = 1'b1;
    applyStimulus(1, 0, 0, 32'h0000BEEF, 0, 1, 0);
    sample();
    checkOutput("ov_hold_valid", ex_valid_o, 1);
    step();
    csr_vxsat_we_i = 1'b0;
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 1);
    exp_q.push_back(32'h0000BEEF);
    sample();
    checkOutput("ov_hold_pre", vxsat_o, 0);
    checkOutput("ov_hold_ready", req_ready_o, 1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    sample();
    checkOutput("ov_hold_vxsat", vxsat_o, 1);

    // Flush in MULTI cycle 2 with both imd writes requested
    step();
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    sample();
    checkOutput("fl_div_en", alu_div_en_o, 1);
    checkOutput("fl_mult_en", alu_mult_en_o, 0);
    step();
    sample();
    step();
    applyStimulus(1, 1, 0, 32'hDEADDEAD, 1, 1, 1);
    flush_i          = 1'b1;
    alu_imd_val_we_i = 2'b11;
    alu_imd_val_d_i  = {34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF};
    sample();
    checkOutput("fl_no_ex_valid", ex_valid_o, 0);
    checkOutput("fl_no_req_ready", req_ready_o, 0);
    step();
    flush_i          = 1'b0;
    alu_imd_val_we_i = 2'b00;
    alu_imd_val_d_i  = '0;
    applyStimulus(1, 0, 0, 32'h00C0FFEE, 0, 0, 1);
    exp_q.push_back(32'h00C0FFEE);
    sample();
    checkOutput("fl_idle_retire", req_ready_o, 1);
    checkOutput("fl_imd0_kept", alu_imd_val_q_o[0], 34'h1_0000_0001);
    checkOutput("fl_imd1_kept", alu_imd_val_q_o[1], 0);
    checkOutput("fl_vxsat_kept", vxsat_o, 1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);

`ifdef IBEX_PEXT_WATCHDOG_EN
    // Watchdog: ALU never completes
    step();
    csr_vxsat_we_i = 1'b1;
    applyStimulus(1, 1, 1, 32'h55555555, 0, 1, 1);
    sample();
    checkOutput("wd_idle", watchdog_err_o, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      csr_vxsat_we_i = 1'b0;
      sample();
      checkOutput("wd_early", watchdog_err_o, 0);
      checkOutput("wd_no_valid", ex_valid_o, 0);
    end
    step();
    exp_q.push_back(32'h0);
    sample();
    checkOutput("wd_pulse", watchdog_err_o, 1);
    checkOutput("wd_retire", req_ready_o, 1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    sample();
    checkOutput("wd_pulse_end", watchdog_err_o, 0);
    checkOutput("wd_vxsat_kept", vxsat_o, 0);
`else
    // Without the watchdog, MULTI waits past any cycle limit
    wd_seen = 1'b0;
    ev_seen = 1'b0;
    step();
    applyStimulus(1, 1, 1, 32'h0, 0, 0, 1);
    for (int i = 0; i < 45; i++) begin
      step();
      sample();
      wd_seen = wd_seen | watchdog_err_o;
      ev_seen = ev_seen | ex_valid_o;
    end
    checkOutput("nowd_err", wd_seen, 0);
    checkOutput("nowd_no_valid", ev_seen, 0);
    checkOutput("nowd_mult_en", alu_mult_en_o, 1);
    step();
    applyStimulus(1, 1, 1, 32'h0BADF00D, 1, 0, 1);
    exp_q.push_back(32'h0BADF00D);
    sample();
    checkOutput("nowd_retire", req_ready_o, 1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
`endif

    repeat (2) step();
    checkOutput("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes + sb_passes, checks + sb_checks);
    $finish;
  end

endmodule
